// File: rtl/mram_serial_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mram_serial_sequencer_if
// Purpose  : Host-side command / write-beat / read-beat bundle of the MRAM
//            serial sequencer.
// Ports    : cmd_*  - command request (valid/ready, write, be, addr, len)
//            wr_*   - write beat supply (valid, data, one-cycle ready pulse)
//            rd_*   - read beat return (valid pulse, data, last)
//            busy   - sequencer not idle
//            master : host / test logic side
//            slave  : sequencer side
// Revision : 1.0 - initial release
// ============================================================================
interface mram_serial_sequencer_if #(
  parameter int FIELD_W = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [1:0]         cmd_be;
  logic [FIELD_W-1:0] cmd_addr;
  logic [FIELD_W-1:0] cmd_len;
  logic               wr_valid;
  logic [FIELD_W-1:0] wr_data;
  logic               wr_ready;
  logic               rd_valid;
  logic [FIELD_W-1:0] rd_data;
  logic               rd_last;
  logic               busy;

  modport master (
    output cmd_valid, cmd_write, cmd_be, cmd_addr, cmd_len, wr_valid, wr_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_be, cmd_addr, cmd_len, wr_valid, wr_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/mram_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mram_serial_sequencer
// Purpose  : Converts parallel host read/write commands into the bit-serial
//            frame protocol of the MRAM integration top, and deserialises
//            read data back to the host. Each transaction is bracketed by a
//            downstream reset.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-low reset
//            host         - command / write / read bundle (slave modport)
//            m_rst        - downstream active-high reset
//            m_burst_en   - burst enable (held for the transaction)
//            m_mode_sel   - mode select (equals burst)
//            m_burst_len  - serial burst length field
//            m_addr       - serial address field
//            m_data       - serial write data field
//            m_rw_sel     - {be_hi, be_lo, write}
//            m_ser_rd     - serial read data from the module
// Revision : 1.0 - initial release
// ============================================================================
module mram_serial_sequencer #(
  parameter int FIELD_W   = 16,
  parameter int PRE_STALL = 2,   // must be >= 1: last stall cycle gates wr_valid
  parameter int POST_GAP  = 2,
  parameter int RST_CYC   = 1,
  parameter int RD_LAT    = 4
) (
  input  wire                    clk,
  input  wire                    rst,
  mram_serial_sequencer_if.slave host,
  output logic                   m_rst,
  output logic                   m_burst_en,
  output logic                   m_mode_sel,
  output logic                   m_burst_len,
  output logic                   m_addr,
  output logic                   m_data,
  output logic [2:0]             m_rw_sel,
  input  wire                    m_ser_rd
);

  localparam int FRAME   = PRE_STALL + FIELD_W + POST_GAP;
  localparam int CNT_MAX = (FRAME > RD_LAT) ? ((FRAME > RST_CYC) ? FRAME : RST_CYC)
                                            : ((RD_LAT > RST_CYC) ? RD_LAT : RST_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(FIELD_W);

  localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] c_stall_last = CNT_W'(PRE_STALL - 1);
  localparam logic [CNT_W-1:0] c_pl_first   = CNT_W'(PRE_STALL);
  localparam logic [CNT_W-1:0] c_pl_last    = CNT_W'(PRE_STALL + FIELD_W - 1);
  localparam logic [CNT_W-1:0] c_rst_last   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] c_rlat_last  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] c_bit_last   = CNT_W'(FIELD_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_CMD   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RDATA = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FIELD_W-1:0] beat_q, beat_d;
  logic               write_q, write_d;
  logic               burst_q, burst_d;
  logic [1:0]         be_q, be_d;
  logic [FIELD_W-1:0] addr_q, addr_d;
  logic [FIELD_W-1:0] len_q, len_d;
  logic [FIELD_W-1:0] wdata_q, wdata_d;
  logic [FIELD_W-2:0] rsh_q, rsh_d;
  logic [FIELD_W-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic               busy_q, busy_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               m_rst_q, m_rst_d;
  logic               burst_out_q, burst_out_d;
  logic [2:0]         m_rw_sel_q, m_rw_sel_d;
  logic               m_addr_q, m_addr_d;
  logic               m_data_q, m_data_d;
  logic               m_burst_len_q, m_burst_len_d;

  logic               wr_take;
  logic               in_payload;
  logic [IDX_W-1:0]   bit_idx;
  logic [FIELD_W-1:0] blen;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    write_d    = write_q;
    burst_d    = burst_q;
    be_d       = be_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    rsh_d      = rsh_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_take    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          state_d = ST_RESET;
          cnt_d   = '0;
          beat_d  = '0;
          write_d = host.cmd_write;
          burst_d = (host.cmd_len != '0);
          be_d    = (host.cmd_len != '0) ? 2'b11 : host.cmd_be;
          addr_d  = host.cmd_addr;
          len_d   = host.cmd_len;
        end
      end

      ST_RESET: begin
        if (cnt_q == c_rst_last) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CMD, ST_WDATA: begin
        // A write frame parks in its last stall cycle until a beat is offered.
        if (!(write_q && (cnt_q == c_stall_last) && !host.wr_valid)) begin
          if (write_q && (cnt_q == c_stall_last)) begin
            wr_take = 1'b1;
            wdata_d = host.wr_data;
          end
          if (cnt_q == c_frame_last) begin
            cnt_d = '0;
            if (!write_q) begin
              state_d = ST_RWAIT;
            end else if (beat_q == len_q) begin
              state_d = ST_DONE;
            end else begin
              beat_d  = beat_q + 1'b1;
              state_d = ST_WDATA;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_RWAIT: begin
        if (cnt_q == c_rlat_last) begin
          state_d = ST_RDATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RDATA: begin
        // Beats are back to back; the shifter is fully overwritten per beat.
        rsh_d = {rsh_q[FIELD_W-3:0], m_ser_rd};
        if (cnt_q == c_bit_last) begin
          rd_data_d  = {rsh_q, m_ser_rd};
          rd_valid_d = 1'b1;
          rd_last_d  = (beat_q == len_q);
          cnt_d      = '0;
          if (beat_q == len_q) begin
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are computed from next-state values so every line is a flop
    // that is valid in the same cycle as the state it describes.
    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
    m_rst_d     = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_DONE);
    burst_out_d = busy_d && burst_d;
    m_rw_sel_d  = busy_d ? {be_d, write_d} : 3'b000;

    in_payload = ((state_d == ST_CMD) || (state_d == ST_WDATA)) &&
                 (cnt_d >= c_pl_first) && (cnt_d <= c_pl_last);
    bit_idx    = IDX_W'(c_pl_last - cnt_d);
    blen       = len_d + 1'b1;

    m_addr_d      = in_payload && (state_d == ST_CMD) && addr_d[bit_idx];
    m_burst_len_d = in_payload && (state_d == ST_CMD) && burst_d && blen[bit_idx];
    m_data_d      = in_payload && write_d && wdata_d[bit_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      beat_q        <= '0;
      write_q       <= 1'b0;
      burst_q       <= 1'b0;
      be_q          <= 2'b00;
      addr_q        <= '0;
      len_q         <= '0;
      wdata_q       <= '0;
      rsh_q         <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      busy_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
      m_rst_q       <= 1'b1;
      burst_out_q   <= 1'b0;
      m_rw_sel_q    <= 3'b000;
      m_addr_q      <= 1'b0;
      m_data_q      <= 1'b0;
      m_burst_len_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      beat_q        <= beat_d;
      write_q       <= write_d;
      burst_q       <= burst_d;
      be_q          <= be_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      wdata_q       <= wdata_d;
      rsh_q         <= rsh_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
      busy_q        <= busy_d;
      cmd_ready_q   <= cmd_ready_d;
      m_rst_q       <= m_rst_d;
      burst_out_q   <= burst_out_d;
      m_rw_sel_q    <= m_rw_sel_d;
      m_addr_q      <= m_addr_d;
      m_data_q      <= m_data_d;
      m_burst_len_q <= m_burst_len_d;
    end
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.wr_ready  = wr_take;
  assign host.rd_valid  = rd_valid_q;
  assign host.rd_data   = rd_data_q;
  assign host.rd_last   = rd_last_q;
  assign host.busy      = busy_q;
  assign m_rst          = m_rst_q;
  assign m_burst_en     = burst_out_q;
  assign m_mode_sel     = burst_out_q;
  assign m_burst_len    = m_burst_len_q;
  assign m_addr         = m_addr_q;
  assign m_data         = m_data_q;
  assign m_rw_sel       = m_rw_sel_q;

endmodule
`default_nettype wire
